// File: rtl/ext_stage.sv
// Immediate extension stage. Results are computed when an operand is accepted
// and held in a two-entry in-order buffer until downstream consumes them.
module ext_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       extop,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] ext_out,
  output logic             err
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and ready depends on registered state only.

  logic [OUT_W-1:0] mem_q [2];
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             push, pop, illegal;
  logic [OUT_W-1:0] zext, sext, res;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign ext_out   = out_valid ? mem_q[rptr_q] : '0;
  assign err       = err_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign zext = {{(OUT_W-IN_W){1'b0}}, imm};
  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (extop)
      3'b000:  res = zext;
      3'b001:  res = sext;
      3'b010:  res = zext << IN_W;
      3'b011:  res = sext << 2;
      3'b100:  res = zext << 2;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    err_d  = err_q || (push && illegal);
    if (flush) begin
      // Flush wins over push and pop; err is deliberately kept.
      wptr_d = 1'b0;
      rptr_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      if (push && !pop)      cnt_d = cnt_q + 2'd1;
      else if (pop && !push) cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
      err_q    <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      if (push && !flush) mem_q[wptr_q] <= res;
    end
  end

endmodule

// File: doc/ext_stage.md
EXT_STAGE -- requirements
Module: ext_stage

Interface
REQ-001 Parameter IN_W, default 16, immediate field width.
REQ-002 Parameter OUT_W, default 32, extended result width; SHALL satisfy OUT_W >= 2*IN_W and OUT_W >= IN_W+2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 in_valid  input  1  upstream offers imm/extop this cycle.
REQ-006 in_ready  output  1  stage accepts an operand this cycle.
REQ-007 imm  input  IN_W  raw immediate field.
REQ-008 extop  input  3  extension mode select.
REQ-009 flush  input  1  synchronous discard of all buffered results.
REQ-010 out_valid  output  1  ext_out holds a valid result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 ext_out  output  OUT_W  extended result, head of buffer.
REQ-013 err  output  1  sticky flag: illegal extop was accepted.

Function
REQ-014 Extension modes SHALL be: 000 zero-extend; 001 sign-extend; 010 upper-load (imm placed at bits [2*IN_W-1:IN_W], all other bits 0); 011 sign-extend then shift left 2 (branch offset); 100 zero-extend then shift left 2.
REQ-015 Codes 101, 110, 111 are illegal; the stage SHALL still accept the operand, store result 0, and set err.
REQ-016 The stage SHALL hold results in a 2-entry in-order buffer; occupancy count in {0,1,2}.
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < 2), derived from registered state only (no combinational path from out_ready).
REQ-019 out_valid SHALL equal (count != 0); ext_out SHALL equal the oldest entry and hold stable while out_valid && !out_ready.
REQ-020 Latency: an operand pushed at edge N SHALL appear on ext_out with out_valid=1 after edge N when the buffer was empty (one cycle).
REQ-021 Results SHALL be computed at push time and stored; later changes on imm/extop do not alter stored entries.
REQ-022 Simultaneous push and pop at count=1: count stays 1, new entry becomes head after the old one leaves.
REQ-023 At count=2 in_ready=0, so no push; a pop alone reduces count to 1.
REQ-024 Pop at count=0 is impossible (out_valid=0); out_ready then has no effect.
REQ-025 flush SHALL set count to 0 at the next edge, discarding stored entries and any same-cycle push; flush takes priority over push and pop.
REQ-026 flush SHALL NOT clear err.
REQ-027 Buffer read/write pointers SHALL wrap modulo 2.
REQ-028 When out_valid=0, ext_out SHALL read 0.

Reset
REQ-029 On reset assertion, asynchronously: count=0, pointers=0, stored entries=0, err=0; hence in_ready=1, out_valid=0, ext_out=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered results; no partial result is emitted after deassertion.
REQ-031 First push is possible on the first rising edge after reset deasserts.

Verification
REQ-032 imm=0x8001 with extop 000/001/010 (out_ready=1) -> ext_out 0x00008001, 0xFFFF8001, 0x80010000, each one cycle after push.
REQ-033 imm=0xFFFF extop=011 -> 0xFFFFFFFC; imm=0x0004 extop=100 -> 0x00000010.
REQ-034 out_ready=0, push 0x0001,0x0002,0x0003 with extop=000 back-to-back -> in_ready=0 after second push, third held; raise out_ready -> outputs 0x1, 0x2, 0x3 in order, no loss or duplication.
REQ-035 extop=111 imm=0x1234 -> ext_out 0x00000000 with out_valid=1, err=1 and stays 1 after flush, clears only on reset.
REQ-036 Buffer full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed operand never appears.
REQ-037 Assert reset asynchronously between edges with count=2 -> out_valid=0, ext_out=0, in_ready=1 immediately, before the next edge.
